// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types, default bounds and load helpers for data_mem_ctrl.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int          c_ADDR_W      = 32;
    localparam int          c_DATA_W      = 32;
    localparam int          c_DEPTH_WORDS = 1024;
    localparam logic [31:0] c_BASE_ADDR   = 32'h0000_0000;
    localparam int          c_PRINT_MAX   = 256;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } print_state_t;

    // Size encoding 3 is reserved and behaves as a word access.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lsb,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lsb +: 8];
        h = word[16*lsb[1] +: 16];
        case (size)
            MEM_BYTE: return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            MEM_HALF: return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default:  return word;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            MEM_BYTE: return 4'b0001 << lsb;
            MEM_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : CPU load/store bus plus print-string request/character stream.
// Revision : 1.0
// ============================================================================
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              misaligned;
    logic              out_of_range;

    logic              print_req;
    logic [ADDR_W-1:0] print_addr;
    logic              print_busy;
    logic              print_done;
    logic              print_err;
    logic              char_valid;
    logic [7:0]        char_data;

    modport master (
        output mem_read, mem_write, mem_size, mem_signed, addr, write_data,
        output print_req, print_addr,
        input  read_data, misaligned, out_of_range,
        input  print_busy, print_done, print_err, char_valid, char_data
    );

    modport slave (
        input  mem_read, mem_write, mem_size, mem_signed, addr, write_data,
        input  print_req, print_addr,
        output read_data, misaligned, out_of_range,
        output print_busy, print_done, print_err, char_valid, char_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl_print_engine.sv
`default_nettype none
// ============================================================================
// Module   : print_engine
// Brief    : Walks a NUL-terminated string one byte per clock over a private
//            byte read port. Only present when PRINT_STRING_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef PRINT_STRING_EN
module print_engine
    import mem_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int PRINT_MAX = c_PRINT_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              print_req,
    input  logic [ADDR_W-1:0] print_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_byte,
    input  logic              rd_oor,
    output logic              print_busy,
    output logic              print_done,
    output logic              print_err,
    output logic              char_valid,
    output logic [7:0]        char_data
);
    localparam int               c_CNT_W   = $clog2(PRINT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRINT_MAX);

    print_state_t        r_state;
    print_state_t        w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic                w_emit;
    logic                w_stop_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && print_req) begin
                r_ptr <= print_addr;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_emit) begin
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_stop_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Range is checked before the byte value: a walk off the end never emits.
    always_comb begin
        w_next     = r_state;
        w_emit     = 1'b0;
        w_stop_err = 1'b0;
        case (r_state)
            IDLE: if (print_req) w_next = WALK;
            WALK: begin
                if (rd_oor) begin
                    w_next     = DONE;
                    w_stop_err = 1'b1;
                end else if (rd_byte == 8'h00 || r_cnt == c_CNT_MAX) begin
                    w_next = DONE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign rd_addr    = r_ptr;
    assign print_busy = (r_state != IDLE);
    assign print_done = (r_state == DONE);
    assign print_err  = r_err;
    assign char_valid = w_emit;
    assign char_data  = w_emit ? rd_byte : 8'h00;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_emit)           $write("%c", rd_byte);
            if (r_state == DONE)  $write("\n");
        end
    end
`endif

endmodule
`endif
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Byte-addressed MEM-stage data memory with optional string-print
//            engine (enabled by defining PRINT_STRING_EN).
// Revision : 1.0
// ============================================================================
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int                ADDR_W      = c_ADDR_W,
    parameter int                DATA_W      = c_DATA_W,
    parameter int                DEPTH_WORDS = c_DEPTH_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(c_BASE_ADDR),
    parameter int                PRINT_MAX   = c_PRINT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_ctrl_if.slave   bus
);
    localparam int                c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] c_SPAN  = ADDR_W'(4 * DEPTH_WORDS);

    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

    logic [ADDR_W:0]    w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_access;
    logic               w_mis;
    logic               w_oor;
    logic               w_err;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  w_word;

    // The extra top bit doubles as a borrow flag for addresses below BASE_ADDR.
    function automatic logic [ADDR_W:0] addr_offset(input logic [ADDR_W-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic offset_in_range(input logic [ADDR_W:0] off);
        return !off[ADDR_W] && (off[ADDR_W-1:0] < c_SPAN);
    endfunction

    always_comb begin
        w_off    = addr_offset(bus.addr);
        w_idx    = w_off[c_IDX_W+1:2];
        w_access = bus.mem_read | bus.mem_write;
        w_mis    = w_access && ((bus.mem_size == MEM_HALF && bus.addr[0]) ||
                                (bus.mem_size[1] && bus.addr[1:0] != 2'b00));
        w_oor    = w_access && !offset_in_range(w_off);
        w_err    = w_mis | w_oor;
        w_word   = r_mem[w_idx];
        w_be     = byte_enable(bus.mem_size, bus.addr[1:0]);
        case (bus.mem_size)
            MEM_BYTE: w_lane = {4{bus.write_data[7:0]}};
            MEM_HALF: w_lane = {2{bus.write_data[15:0]}};
            default:  w_lane = bus.write_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.mem_write && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_lane[8*k +: 8];
            end
        end
    end

    assign bus.read_data    = w_err ? '0 : load_extend(w_word, bus.addr[1:0], bus.mem_size, bus.mem_signed);
    assign bus.misaligned   = w_mis;
    assign bus.out_of_range = w_oor;

    logic w_unused_cpu;
    assign w_unused_cpu = &{1'b0, w_off[ADDR_W:c_IDX_W+2], w_off[1:0]};

`ifdef PRINT_STRING_EN
    logic [ADDR_W-1:0] w_pb_addr;
    logic [ADDR_W:0]   w_pb_off;
    logic [DATA_W-1:0] w_pb_word;
    logic [7:0]        w_pb_byte;
    logic              w_pb_oor;

    // Second read port sees pre-store contents, so a same-cycle store to the
    // walked byte only affects later bytes.
    always_comb begin
        w_pb_off  = addr_offset(w_pb_addr);
        w_pb_oor  = !offset_in_range(w_pb_off);
        w_pb_word = r_mem[w_pb_off[c_IDX_W+1:2]];
        w_pb_byte = w_pb_word[8*w_pb_addr[1:0] +: 8];
    end

    logic w_unused_pb;
    assign w_unused_pb = &{1'b0, w_pb_off[ADDR_W:c_IDX_W+2], w_pb_off[1:0]};

    print_engine #(
        .ADDR_W    (ADDR_W),
        .PRINT_MAX (PRINT_MAX)
    ) u_print_engine (
        .clk        (clk),
        .reset      (reset),
        .print_req  (bus.print_req),
        .print_addr (bus.print_addr),
        .rd_addr    (w_pb_addr),
        .rd_byte    (w_pb_byte),
        .rd_oor     (w_pb_oor),
        .print_busy (bus.print_busy),
        .print_done (bus.print_done),
        .print_err  (bus.print_err),
        .char_valid (bus.char_valid),
        .char_data  (bus.char_data)
    );
`else
    assign bus.print_busy = 1'b0;
    assign bus.print_done = 1'b0;
    assign bus.print_err  = 1'b0;
    assign bus.char_valid = 1'b0;
    assign bus.char_data  = 8'h00;

    logic w_unused_print;
    assign w_unused_print = &{1'b0, reset, bus.print_req, bus.print_addr, (PRINT_MAX > 0)};
`endif

endmodule
`default_nettype wire
